// File: rtl/hazard_pkg.sv
// Shared constants and types for the multicycle-aware hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE,
    MC_BUSY
  } mcState_e;

  // The countdown only ever holds MC_LAT-2, so clog2(MC_LAT) bits are enough.
  function automatic int mcCntWidth(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_mc_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);

  logic [AW-1:0]    Rs1D;
  logic [AW-1:0]    Rs2D;
  logic             use_rs1D;
  logic             use_rs2D;
  logic [AW-1:0]    Rs1E;
  logic [AW-1:0]    Rs2E;
  logic [AW-1:0]    RdE;
  logic [AW-1:0]    RdM;
  logic [AW-1:0]    RdW;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             ResultSrcE0;
  logic             McE;
  logic             PCSrcE;
  logic             MemReqM;
  logic             dmem_ready;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlushW;
  logic             mc_lastE;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, use_rs1D, use_rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, McE, PCSrcE,
           MemReqM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, mc_lastE, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, use_rs1D, use_rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, McE, PCSrcE,
           MemReqM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, mc_lastE, stall_cnt
  );

endinterface

// File: rtl/fwd_sel.sv
// Forward select for one E-stage source operand; M result wins over W result.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          regWriteM,
  input  logic          regWriteW,
  output logic [1:0]    fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (FWD_EN && (rsE != '0)) begin
      if (regWriteM && (rsE == rdM)) begin
        fwdSel = FWD_MEM;
      end else if (regWriteW && (rsE == rdW)) begin
        fwdSel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: forwarding, load-use/RAW stalls, branch flushes,
// fixed-latency multicycle-execute stall FSM, data-memory wait freeze, stall counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MC_LAT = 34,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input logic             clk,
  input logic             rst,
  hazard_ctrl_mc_if.slave hz
);

  localparam int                  CNT_BITS = mcCntWidth(MC_LAT);
  localparam bit                  MC_MULTI = (MC_LAT > 1);
  localparam logic [CNT_BITS-1:0] MC_LOAD  = CNT_BITS'(MC_MULTI ? MC_LAT - 2 : 0);

  mcState_e            state;
  mcState_e            stateNext;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cntNext;
  logic [CNT_W-1:0]    stallCnt;

  logic rs1Hit;
  logic rs2Hit;
  logic rawHit;
  logic memWait;
  logic mcStall;
  logic mcLast;
  logic stallF;
  logic stallD;
  logic stallE;
  logic stallM;
  logic flushD;
  logic flushE;
  logic flushM;
  logic flushW;

  fwd_sel #(.AW(AW), .FWD_EN(FWD_EN)) uFwdA (
    .rsE       (hz.Rs1E),
    .rdM       (hz.RdM),
    .rdW       (hz.RdW),
    .regWriteM (hz.RegWriteM),
    .regWriteW (hz.RegWriteW),
    .fwdSel    (hz.ForwardAE)
  );

  fwd_sel #(.AW(AW), .FWD_EN(FWD_EN)) uFwdB (
    .rsE       (hz.Rs2E),
    .rdM       (hz.RdM),
    .rdW       (hz.RdW),
    .regWriteM (hz.RegWriteM),
    .regWriteW (hz.RegWriteW),
    .fwdSel    (hz.ForwardBE)
  );

  // Without forwarding, any in-flight writer in E or M must be waited out.
  always_comb begin
    rs1Hit = 1'b0;
    rs2Hit = 1'b0;
    if (hz.use_rs1D && (hz.Rs1D != '0)) begin
      rs1Hit = ((hz.Rs1D == hz.RdE) && hz.RegWriteE && (hz.ResultSrcE0 || !FWD_EN))
             || (!FWD_EN && (hz.Rs1D == hz.RdM) && hz.RegWriteM);
    end
    if (hz.use_rs2D && (hz.Rs2D != '0)) begin
      rs2Hit = ((hz.Rs2D == hz.RdE) && hz.RegWriteE && (hz.ResultSrcE0 || !FWD_EN))
             || (!FWD_EN && (hz.Rs2D == hz.RdM) && hz.RegWriteM);
    end
  end

  assign rawHit  = rs1Hit || rs2Hit;
  assign memWait = hz.MemReqM && !hz.dmem_ready;
  assign mcStall = ((state == IDLE) && hz.McE && MC_MULTI)
                || ((state == MC_BUSY) && (cnt != '0));
  assign mcLast  = ((state == MC_BUSY) && (cnt == '0))
                || ((state == IDLE) && hz.McE && !MC_MULTI);

  // Fixed priority; everything but forwarding is held low while in reset.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      if (memWait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (mcStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (hz.PCSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (rawHit) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // A memory wait freezes the countdown so the op still spends MC_LAT cycles in E.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (!memWait) begin
      case (state)
        IDLE: begin
          if (hz.McE && MC_MULTI) begin
            stateNext = MC_BUSY;
            cntNext   = MC_LOAD;
          end
        end
        MC_BUSY: begin
          if (cnt != '0) begin
            cntNext = cnt - CNT_BITS'(1);
          end else begin
            stateNext = IDLE;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (stallF && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign hz.StallF    = stallF;
  assign hz.StallD    = stallD;
  assign hz.StallE    = stallE;
  assign hz.StallM    = stallM;
  assign hz.FlushD    = flushD;
  assign hz.FlushE    = flushE;
  assign hz.FlushM    = flushM;
  assign hz.FlushW    = flushW;
  assign hz.mc_lastE  = rst && mcLast;
  assign hz.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench: dut1 forwards with MC_LAT=4; dut0 is stall-only, MC_LAT=1, 3-bit counter.
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.AW(5), .CNT_W(32)) hz1 ();
  hazard_ctrl_mc_if #(.AW(5), .CNT_W(3))  hz0 ();

  assign hz0.Rs1D        = hz1.Rs1D;
  assign hz0.Rs2D        = hz1.Rs2D;
  assign hz0.use_rs1D    = hz1.use_rs1D;
  assign hz0.use_rs2D    = hz1.use_rs2D;
  assign hz0.Rs1E        = hz1.Rs1E;
  assign hz0.Rs2E        = hz1.Rs2E;
  assign hz0.RdE         = hz1.RdE;
  assign hz0.RdM         = hz1.RdM;
  assign hz0.RdW         = hz1.RdW;
  assign hz0.RegWriteE   = hz1.RegWriteE;
  assign hz0.RegWriteM   = hz1.RegWriteM;
  assign hz0.RegWriteW   = hz1.RegWriteW;
  assign hz0.ResultSrcE0 = hz1.ResultSrcE0;
  assign hz0.McE         = hz1.McE;
  assign hz0.PCSrcE      = hz1.PCSrcE;
  assign hz0.MemReqM     = hz1.MemReqM;
  assign hz0.dmem_ready  = hz1.dmem_ready;

  hazard_ctrl_mc #(.AW(5), .MC_LAT(4), .FWD_EN(1'b1), .CNT_W(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (hz1.slave)
  );

  hazard_ctrl_mc #(.AW(5), .MC_LAT(1), .FWD_EN(1'b0), .CNT_W(3)) dut0 (
    .clk (clk),
    .rst (rst),
    .hz  (hz0.slave)
  );

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}
  logic [11:0] out1;
  logic [11:0] out0;
  assign out1 = {hz1.ForwardAE, hz1.ForwardBE, hz1.StallF, hz1.StallD, hz1.StallE,
                 hz1.StallM, hz1.FlushD, hz1.FlushE, hz1.FlushM, hz1.FlushW};
  assign out0 = {hz0.ForwardAE, hz0.ForwardBE, hz0.StallF, hz0.StallD, hz0.StallE,
                 hz0.StallM, hz0.FlushD, hz0.FlushE, hz0.FlushM, hz0.FlushW};

  typedef struct {
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        use1;
    logic        use2;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic [4:0]  rdM;
    logic [4:0]  rdW;
    logic        weE;
    logic        weM;
    logic        weW;
    logic        ldE;
    logic        brE;
    logic        memReq;
    logic        memRdy;
    logic [11:0] exp1;
    logic [11:0] exp0;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  int nCompared   = 0;
  int nMismatched = 0;

  int kindA[5] = '{1, 1, 1, 0, 0};
  int lastA[5] = '{0, 0, 0, 1, 0};
  int kindB[7] = '{1, 1, 2, 2, 1, 0, 0};
  int lastB[7] = '{0, 0, 0, 0, 0, 1, 0};

  function automatic vec_t mkVec(
    input int rs1D, input int rs2D, input int use1, input int use2,
    input int rs1E, input int rs2E, input int rdE, input int rdM, input int rdW,
    input int weE, input int weM, input int weW,
    input int ldE, input int brE, input int memReq, input int memRdy,
    input int exp1, input int exp0);
    vec_t v;
    v.rs1D   = 5'(rs1D);
    v.rs2D   = 5'(rs2D);
    v.use1   = 1'(use1);
    v.use2   = 1'(use2);
    v.rs1E   = 5'(rs1E);
    v.rs2E   = 5'(rs2E);
    v.rdE    = 5'(rdE);
    v.rdM    = 5'(rdM);
    v.rdW    = 5'(rdW);
    v.weE    = 1'(weE);
    v.weM    = 1'(weM);
    v.weW    = 1'(weW);
    v.ldE    = 1'(ldE);
    v.brE    = 1'(brE);
    v.memReq = 1'(memReq);
    v.memRdy = 1'(memRdy);
    v.exp1   = 12'(exp1);
    v.exp0   = 12'(exp0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    hz1.Rs1D        = '0;
    hz1.Rs2D        = '0;
    hz1.use_rs1D    = 1'b0;
    hz1.use_rs2D    = 1'b0;
    hz1.Rs1E        = '0;
    hz1.Rs2E        = '0;
    hz1.RdE         = '0;
    hz1.RdM         = '0;
    hz1.RdW         = '0;
    hz1.RegWriteE   = 1'b0;
    hz1.RegWriteM   = 1'b0;
    hz1.RegWriteW   = 1'b0;
    hz1.ResultSrcE0 = 1'b0;
    hz1.McE         = 1'b0;
    hz1.PCSrcE      = 1'b0;
    hz1.MemReqM     = 1'b0;
    hz1.dmem_ready  = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    hz1.Rs1D        = v.rs1D;
    hz1.Rs2D        = v.rs2D;
    hz1.use_rs1D    = v.use1;
    hz1.use_rs2D    = v.use2;
    hz1.Rs1E        = v.rs1E;
    hz1.Rs2E        = v.rs2E;
    hz1.RdE         = v.rdE;
    hz1.RdM         = v.rdM;
    hz1.RdW         = v.rdW;
    hz1.RegWriteE   = v.weE;
    hz1.RegWriteM   = v.weM;
    hz1.RegWriteW   = v.weW;
    hz1.ResultSrcE0 = v.ldE;
    hz1.McE         = 1'b0;
    hz1.PCSrcE      = v.brE;
    hz1.MemReqM     = v.memReq;
    hz1.dmem_ready  = v.memRdy;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // kind: 0 = quiet, 1 = multicycle stall, 2 = memory-wait freeze
  task automatic checkMc(input string name, input int kind, input int last);
    logic [11:0] e;
    case (kind)
      1:       e = 12'b0000_1110_0010;
      2:       e = 12'b0000_1111_0001;
      default: e = 12'b0000_0000_0000;
    endcase
    checkOutput({name, ".out"}, 32'(out1), 32'(e));
    checkOutput({name, ".last"}, 32'(hz1.mc_lastE), 32'(last));
  endtask

  initial begin
    vecs[0]  = mkVec(0, 0, 0, 0,  5, 0, 0, 5, 5,  0, 1, 1,  0, 0, 0, 1,  'h800, 'h000);
    vecs[1]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 1,  0, 0, 0, 1,  'h000, 'h000);
    vecs[2]  = mkVec(0, 0, 0, 0,  3, 3, 0, 4, 3,  0, 1, 1,  0, 0, 0, 1,  'h500, 'h000);
    vecs[3]  = mkVec(0, 0, 0, 0,  0, 6, 0, 6, 6,  0, 0, 1,  0, 0, 0, 1,  'h100, 'h000);
    vecs[4]  = mkVec(0, 7, 0, 1,  0, 0, 7, 0, 0,  1, 0, 0,  1, 0, 0, 1,  'h0C4, 'h0C4);
    vecs[5]  = mkVec(0, 7, 0, 0,  0, 0, 7, 0, 0,  1, 0, 0,  1, 0, 0, 1,  'h000, 'h000);
    vecs[6]  = mkVec(0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0, 1,  'h000, 'h000);
    vecs[7]  = mkVec(7, 0, 1, 0,  0, 0, 7, 0, 0,  1, 0, 0,  0, 0, 0, 1,  'h000, 'h0C4);
    vecs[8]  = mkVec(9, 0, 1, 0,  0, 0, 0, 9, 0,  0, 1, 0,  0, 0, 0, 1,  'h000, 'h0C4);
    vecs[9]  = mkVec(9, 0, 1, 0,  0, 0, 0, 0, 9,  0, 0, 1,  0, 0, 0, 1,  'h000, 'h000);
    vecs[10] = mkVec(0, 7, 0, 1,  0, 0, 7, 0, 0,  1, 0, 0,  1, 1, 0, 1,  'h00C, 'h00C);
    vecs[11] = mkVec(0, 7, 0, 1,  0, 0, 7, 0, 0,  1, 0, 0,  1, 1, 1, 0,  'h0F1, 'h0F1);
    vecs[12] = mkVec(0, 0, 0, 0,  5, 0, 0, 5, 0,  0, 1, 0,  0, 0, 1, 1,  'h800, 'h000);
    vecs[13] = mkVec(7, 0, 1, 0,  0, 0, 7, 0, 0,  0, 0, 0,  1, 0, 0, 1,  'h000, 'h000);
    vecs[14] = mkVec(0, 0, 0, 0,  5, 0, 0, 5, 0,  0, 1, 0,  0, 0, 1, 0,  'h8F1, 'h0F1);
    vecs[15] = mkVec(7, 3, 1, 1,  7, 3, 7, 0, 0,  1, 0, 0,  1, 0, 0, 1,  'h0C4, 'h0C4);

    // Reset: forwarding stays live, everything else is forced low.
    rst = 1'b0;
    clearInputs();
    hz1.Rs1E       = 5'd5;
    hz1.RdM        = 5'd5;
    hz1.RegWriteM  = 1'b1;
    hz1.MemReqM    = 1'b1;
    hz1.dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset.out1", 32'(out1), 32'h800);
    checkOutput("reset.out0", 32'(out0), 32'h000);
    checkOutput("reset.last", 32'(hz1.mc_lastE), 32'd0);
    checkOutput("reset.cnt", hz1.stall_cnt, 32'd0);
    @(negedge clk);
    clearInputs();
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d.dut1", i), 32'(out1), 32'(vecs[i].exp1));
      checkOutput($sformatf("vec%0d.dut0", i), 32'(out0), 32'(vecs[i].exp0));
      checkOutput($sformatf("vec%0d.last", i), 32'(hz1.mc_lastE), 32'd0);
    end

    // Multicycle op, MC_LAT=4: three stall cycles then the last-cycle pulse.
    doReset();
    hz1.McE = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) hz1.McE = 1'b0;
      #1;
      checkMc($sformatf("mcA.c%0d", c), kindA[c], lastA[c]);
      if (c < 4) begin
        checkOutput($sformatf("mcA.c%0d.dut0out", c), 32'(out0), 32'h000);
        checkOutput($sformatf("mcA.c%0d.dut0last", c), 32'(hz0.mc_lastE), 32'd1);
      end
      @(negedge clk);
    end
    checkOutput("mcA.cnt1", hz1.stall_cnt, 32'd3);
    checkOutput("mcA.cnt0", 32'(hz0.stall_cnt), 32'd0);

    // Two memory-wait cycles in the middle of the countdown.
    doReset();
    for (int c = 0; c < 7; c++) begin
      hz1.McE        = (c < 6);
      hz1.MemReqM    = (c == 2) || (c == 3);
      hz1.dmem_ready = !((c == 2) || (c == 3));
      #1;
      checkMc($sformatf("mcB.c%0d", c), kindB[c], lastB[c]);
      @(negedge clk);
    end
    checkOutput("mcB.cnt1", hz1.stall_cnt, 32'd5);
    checkOutput("mcB.cnt0", 32'(hz0.stall_cnt), 32'd2);

    // Reset asserted while the multicycle FSM is busy.
    doReset();
    hz1.McE = 1'b1;
    #1;
    checkMc("rstC.c0", 1, 0);
    @(negedge clk);
    #1;
    checkMc("rstC.c1", 1, 0);
    #2;
    rst           = 1'b0;
    hz1.Rs1E      = 5'd5;
    hz1.RdM       = 5'd5;
    hz1.RegWriteM = 1'b1;
    #1;
    checkOutput("rstC.async.out", 32'(out1), 32'h800);
    checkOutput("rstC.async.last", 32'(hz1.mc_lastE), 32'd0);
    checkOutput("rstC.async.cnt", hz1.stall_cnt, 32'd0);
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    #1;
    checkMc("rstC.rel0", 0, 0);
    @(negedge clk);
    #1;
    checkMc("rstC.rel1", 0, 0);
    checkOutput("rstC.rel.cnt", hz1.stall_cnt, 32'd0);

    // Saturation of the 3-bit stall counter in dut0.
    doReset();
    hz1.MemReqM    = 1'b1;
    hz1.dmem_ready = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checkOutput("sat.cnt0", 32'(hz0.stall_cnt), 32'd7);
    checkOutput("sat.cnt1", hz1.stall_cnt, 32'd9);
    clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It generates forwarding selects, stalls and flushes, like the existing hazard logic. It adds:
- x0- and operand-use-qualified load-use detection;
- a stall-only mode with forwarding disabled;
- a fixed-latency multicycle-execute (MUL/DIV) stall FSM;
- a data-memory wait freeze;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives the enable/clear pins of the F/D, D/E, E/M and M/W pipeline registers.

## Interface
Parameters:
- AW, 5, register-address width (4 for RV32E).
- MC_LAT, 34, total cycles a multicycle op occupies E; must be ≥1.
- FWD_EN, 1, 1 = forward from M/W; 0 = resolve every RAW hazard by stalling.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  AW  source registers in D.
- use_rs1D, use_rs2D  in  1  instruction in D actually reads Rs1D / Rs2D.
- Rs1E, Rs2E, RdE  in  AW  sources and destination in E.
- RdM, RdW  in  AW  destinations in M, W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables.
- ResultSrcE0  in  1  instruction in E is a load.
- McE  in  1  instruction in E is multicycle.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemReqM  in  1  memory access in M.
- dmem_ready  in  1  data memory completes this cycle.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the stage register.
- FlushD, FlushE, FlushM, FlushW  out  1  insert a bubble into the stage register.
- mc_lastE  out  1  final cycle of a multicycle op in E; the unit presents its result.
- stall_cnt  out  CNT_W  count of cycles with StallF=1.

## Operation
- **Forwarding (FWD_EN=1):**
  - ForwardAE=10 if Rs1E==RdM & RegWriteM & Rs1E≠0.
  - Else ForwardAE=01 if Rs1E==RdW & RegWriteW & Rs1E≠0.
  - Else ForwardAE=00. ForwardBE is the same using Rs2E.
  - With FWD_EN=0 both selects are forced to 00.
- **raw hit:** for each used D source (use_rsxD=1, Rs≠0), true if it matches RdE with RegWriteE & ResultSrcE0. With FWD_EN=0 it additionally matches RdE with RegWriteE, or RdM with RegWriteM.
- **Priority, highest first:**
  1. **mem_wait** = MemReqM & ~dmem_ready. Assert StallF/D/E/M and FlushW. No other flush. FSM and counter freeze.
  2. **mc_stall.** In IDLE with McE & MC_LAT>1, or in MC_BUSY with cnt≠0: assert StallF/D/E and FlushM.
  3. **branch.** PCSrcE: assert FlushD and FlushE. Suppresses the load-use stall.
  4. **load-use** (raw hit): assert StallF/D and FlushE.
- **FSM, IDLE/MC_BUSY:**
  - IDLE → MC_BUSY when McE & MC_LAT>1 & ~mem_wait; load cnt=MC_LAT-2.
  - In MC_BUSY with cnt≠0: cnt decrements.
  - In MC_BUSY with cnt==0: mc_lastE=1, no mc stall, → IDLE; McE is ignored in this cycle.
  - In IDLE with McE & MC_LAT==1: mc_lastE=1 and no stall.
- PCSrcE is ignored while StallE=1.
- stall_cnt increments when StallF=1 and saturates at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state. Zero-cycle latency.
- A multicycle op stalls the pipeline for exactly MC_LAT-1 cycles, plus any mem_wait cycles.
- While rst=0:
  - state=IDLE, cnt=0, stall_cnt=0;
  - all Stall*, Flush* and mc_lastE are forced to 0;
  - Forward* are still computed.
- Reset in mid-operation aborts MC_BUSY immediately.
- Simultaneous mem_wait and mc_stall: mem_wait outputs only; the FSM holds.
- A load-use hit while mc_stall is active is hidden until E advances.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the FSM state type {IDLE, MC_BUSY}.
- One sub-module, fwd_sel, compares one source register and produces its forward select. It is instantiated twice (A and B) and receives FWD_EN.

## Test plan
- **Forward priority:** Rs1E=5, RdM=5, RdW=5, both RegWrite=1 → ForwardAE=10. With Rs1E=0 → 00. With FWD_EN=0 → 00.
- **Load-use:** ResultSrcE0=1, RdE=7, RegWriteE=1, Rs2D=7, use_rs2D=1 → StallF=StallD=FlushE=1. With use_rs2D=0, or RdE=0 → no stall.
- **Multicycle, MC_LAT=4:** McE=1 → StallF/D/E and FlushM high for 3 cycles. mc_lastE pulses in the 4th cycle. stall_cnt increases by 3.
- **mem_wait inside MC_BUSY:** dmem_ready=0 for 2 cycles mid-countdown → StallM and FlushW asserted, FlushM=0, cnt frozen. Total stall = 3+2 cycles.
- **Branch vs load-use together:** PCSrcE=1 with a load-use hit → FlushD=FlushE=1, StallF=StallD=0.
- **Reset mid-operation:** rst=0 during MC_BUSY → all stalls and flushes drop asynchronously. After release: state IDLE, stall_cnt=0.
